// File: rtl/hi_15_tag_decoder.sv
// Slices correlator amplitude reports, finds the 424 kHz SOF, Manchester-decodes LSB-first bytes, flags EOF/abort.
// Outputs land two clocks after the deciding report's strobe; no backpressure, reports are consumed as they arrive.
module hi_15_tag_decoder #(
  parameter logic [13:0] THR_HI    = 14'd160,
  parameter logic [13:0] THR_LO    = 14'd96,
  parameter int          MAX_BYTES = 64
) (
  input  logic        ck_1356meg,
  input  logic        reset,
  input  logic        corr_valid,
  input  logic [13:0] corr_amplitude,
  input  logic        enable,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        frame_active,
  output logic        frame_done,
  output logic        frame_error,
  output logic [9:0]  bit_cnt
);
  typedef enum logic [1:0] {IDLE, SOF_OFF, SOF_ON2, DATA} state_t;

  state_t      state_q, state_d;
  logic        lvl_q, lvl_d, rep_q, rep_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  phase_q, phase_d, h1_q, h1_d, h2_q, h2_d;
  logic        pend_q, pend_d, pend_vld_q, pend_vld_d;
  logic [7:0]  sh_q, sh_d, byte_out_q, byte_out_d;
  logic [6:0]  byte_cnt_q, byte_cnt_d;
  logic        byte_valid_q, byte_valid_d, frame_active_q, frame_active_d;
  logic        frame_done_q, frame_done_d, frame_error_q, frame_error_d;
  logic [9:0]  bit_cnt_q, bit_cnt_d;
  logic        end_frame, end_err;
  logic [2:0]  h1_n, h2_n;
  logic        sym0, sym1, sym_e;

  // Half-symbol tallies including the report being processed now.
  assign h1_n  = h1_q + {2'b00, lvl_q & ~phase_q[2]};
  assign h2_n  = h2_q + {2'b00, lvl_q & phase_q[2]};
  assign sym0  = (h1_n >= 3'd3) && (h2_n <= 3'd1);
  assign sym1  = (h1_n <= 3'd1) && (h2_n >= 3'd3);
  assign sym_e = (h1_n >= 3'd3) && (h2_n >= 3'd3);

  always_comb begin
    state_d        = state_q;
    lvl_d          = lvl_q;
    rep_d          = 1'b0;
    cnt_d          = cnt_q;
    phase_d        = phase_q;
    h1_d           = h1_q;
    h2_d           = h2_q;
    pend_d         = pend_q;
    pend_vld_d     = pend_vld_q;
    sh_d           = sh_q;
    byte_cnt_d     = byte_cnt_q;
    byte_out_d     = byte_out_q;
    byte_valid_d   = 1'b0;
    frame_active_d = frame_active_q;
    frame_done_d   = 1'b0;
    frame_error_d  = frame_error_q;
    bit_cnt_d      = bit_cnt_q;
    end_frame      = 1'b0;
    end_err        = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      if (frame_active_q) begin
        frame_done_d   = 1'b1;
        frame_error_d  = 1'b1;
        frame_active_d = 1'b0;
      end
    end else begin
      if (corr_valid) begin
        rep_d = 1'b1;
        if (corr_amplitude >= THR_HI)     lvl_d = 1'b1;
        else if (corr_amplitude < THR_LO) lvl_d = 1'b0;
      end
      if (rep_q) begin
        case (state_q)
          IDLE: begin
            if (lvl_q) begin
              if (cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
            end else if (cnt_q >= 4'd11 && cnt_q <= 4'd13) begin
              state_d = SOF_OFF;
              cnt_d   = 4'd1;
            end else begin
              cnt_d = 4'd0;
            end
          end
          SOF_OFF: begin
            // The off-run counter never exceeds 5 here, so an on report only needs the lower bound.
            if (!lvl_q) begin
              if (cnt_q >= 4'd5) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
              end else begin
                cnt_d = cnt_q + 4'd1;
              end
            end else if (cnt_q >= 4'd3) begin
              state_d = SOF_ON2;
              cnt_d   = 4'd1;
            end else begin
              state_d = IDLE;
              cnt_d   = 4'd1;
            end
          end
          SOF_ON2: begin
            if (!lvl_q) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
            end else if (cnt_q == 4'd3) begin
              state_d        = DATA;
              cnt_d          = 4'd0;
              phase_d        = 3'd0;
              h1_d           = 3'd0;
              h2_d           = 3'd0;
              pend_vld_d     = 1'b0;
              sh_d           = 8'd0;
              byte_cnt_d     = 7'd0;
              bit_cnt_d      = 10'd0;
              frame_active_d = 1'b1;
              frame_error_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          DATA: begin
            phase_d = phase_q + 3'd1;
            h1_d    = h1_n;
            h2_d    = h2_n;
            if (phase_q == 3'd7) begin
              h1_d = 3'd0;
              h2_d = 3'd0;
              if (sym0 || sym1) begin
                if (pend_vld_q) begin
                  sh_d      = {pend_q, sh_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 10'd1;
                  if (bit_cnt_d[2:0] == 3'd0) begin
                    byte_out_d   = sh_d;
                    byte_valid_d = 1'b1;
                    byte_cnt_d   = byte_cnt_q + 7'd1;
                    if (byte_cnt_d == 7'(MAX_BYTES)) begin
                      end_frame = 1'b1;
                      end_err   = 1'b1;
                    end
                  end
                end
                pend_vld_d = 1'b1;
                pend_d     = sym1;
              end else if (sym_e && pend_vld_q && !pend_q) begin
                end_frame = 1'b1;
                end_err   = (bit_cnt_q[2:0] != 3'd0);
              end else begin
                end_frame = 1'b1;
                end_err   = 1'b1;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
      if (end_frame) begin
        state_d        = IDLE;
        cnt_d          = 4'd0;
        frame_done_d   = 1'b1;
        frame_error_d  = end_err;
        frame_active_d = 1'b0;
      end
    end
  end

  always_ff @(negedge ck_1356meg) begin
    if (reset) begin
      state_q        <= IDLE;
      lvl_q          <= 1'b0;
      rep_q          <= 1'b0;
      cnt_q          <= 4'd0;
      phase_q        <= 3'd0;
      h1_q           <= 3'd0;
      h2_q           <= 3'd0;
      pend_q         <= 1'b0;
      pend_vld_q     <= 1'b0;
      sh_q           <= 8'd0;
      byte_cnt_q     <= 7'd0;
      byte_out_q     <= 8'd0;
      byte_valid_q   <= 1'b0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_error_q  <= 1'b0;
      bit_cnt_q      <= 10'd0;
    end else begin
      state_q        <= state_d;
      lvl_q          <= lvl_d;
      rep_q          <= rep_d;
      cnt_q          <= cnt_d;
      phase_q        <= phase_d;
      h1_q           <= h1_d;
      h2_q           <= h2_d;
      pend_q         <= pend_d;
      pend_vld_q     <= pend_vld_d;
      sh_q           <= sh_d;
      byte_cnt_q     <= byte_cnt_d;
      byte_out_q     <= byte_out_d;
      byte_valid_q   <= byte_valid_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      frame_error_q  <= frame_error_d;
      bit_cnt_q      <= bit_cnt_d;
    end
  end

  assign byte_out     = byte_out_q;
  assign byte_valid   = byte_valid_q;
  assign frame_active = frame_active_q;
  assign frame_done   = frame_done_q;
  assign frame_error  = frame_error_q;
  assign bit_cnt      = bit_cnt_q;
endmodule

// File: tb/tb_hi_15_tag_decoder.sv
// Drives slicer-level frames built from symbol rules and compares decoded bytes and frame status
// against what the encoded frame should yield.
`timescale 1ns/1ps
module tb_hi_15_tag_decoder;
  localparam int THR_HI = 160;
  localparam int THR_LO = 96;

  logic        clk = 1'b0;
  logic        reset, corr_valid, enable;
  logic [13:0] amp;
  logic [7:0]  byte_out;
  logic        byte_valid, frame_active, frame_done, frame_error;
  logic [9:0]  bit_cnt;

  hi_15_tag_decoder dut (
    .ck_1356meg(clk), .reset(reset), .corr_valid(corr_valid), .corr_amplitude(amp),
    .enable(enable), .byte_out(byte_out), .byte_valid(byte_valid), .frame_active(frame_active),
    .frame_done(frame_done), .frame_error(frame_error), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         gap = 16;
  bit         prev_l = 1'b0;
  logic [7:0] rx_q[$];
  int         done_cnt = 0;
  bit         last_err = 1'b0;
  int         last_bc = 0;
  bit         act_seen = 1'b0;
  time        last_cv = 0, eof_cv = 0, done_t = 0;

  // Observes outputs on the posedge; the DUT updates on the negedge.
  always @(posedge clk) begin
    if (byte_valid) rx_q.push_back(byte_out);
    if (frame_done) begin
      done_cnt++;
      last_err = frame_error;
      last_bc  = int'(bit_cnt);
      done_t   = $time;
    end
    if (frame_active) act_seen = 1'b1;
  end

  task automatic rep_amp(input logic [13:0] a);
    @(posedge clk);
    corr_valid = 1'b1;
    amp        = a;
    last_cv    = $time;
    @(posedge clk);
    corr_valid = 1'b0;
    repeat (gap - 2) @(posedge clk);
  endtask

  // Amplitude for a wanted level; a repeat of the same level may use the hysteresis band.
  task automatic rep(input bit l);
    logic [13:0] a;
    if (l == prev_l && $urandom_range(0, 3) == 0) a = 14'($urandom_range(THR_LO, THR_HI - 1));
    else if (l) a = 14'($urandom_range(THR_HI, 16383));
    else a = 14'($urandom_range(0, THR_LO - 1));
    prev_l = l;
    rep_amp(a);
  endtask

  task automatic reps(input bit l, input int n);
    repeat (n) rep(l);
  endtask

  task automatic send_sof();
    reps(1'b1, 12); reps(1'b0, 4); reps(1'b1, 4);
  endtask

  task automatic send_bit(input bit b);
    reps(!b, 4); reps(b, 4);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_eof();
    send_bit(1'b0); reps(1'b1, 8); eof_cv = last_cv; reps(1'b1, 4);
  endtask

  task automatic idle_gap();
    reps(1'b0, 8);
  endtask

  task automatic clr_mon();
    rx_q.delete(); done_cnt = 0; act_seen = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; corr_valid = 1'b0; amp = 14'd0; prev_l = 1'b0;
    repeat (3) @(posedge clk);
    n_cmp++; if (byte_out !== 8'd0) begin n_bad++; $display("FAIL reset_byte_out: got %h want 00", byte_out); end
    n_cmp++; if (bit_cnt !== 10'd0) begin n_bad++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
    n_cmp++; if ({byte_valid, frame_active, frame_done, frame_error} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {byte_valid, frame_active, frame_done, frame_error});
    end
    reset = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_a5_frame();
    clr_mon(); idle_gap(); send_sof(); send_byte(8'hA5); send_eof(); idle_gap();
    n_cmp++; if (rx_q.size() != 1) begin n_bad++; $display("FAIL a5_count: got %0d want 1", rx_q.size()); end
    else begin
      n_cmp++; if (rx_q[0] !== 8'hA5) begin n_bad++; $display("FAIL a5_byte: got %h want a5", rx_q[0]); end
    end
    n_cmp++; if (done_cnt != 1 || last_err !== 1'b0) begin
      n_bad++; $display("FAIL a5_done: got %0d/%b want 1/0", done_cnt, last_err);
    end
    n_cmp++; if (last_bc != 8) begin n_bad++; $display("FAIL a5_bit_cnt: got %0d want 8", last_bc); end
    n_cmp++; if (done_t - eof_cv != 20) begin n_bad++; $display("FAIL a5_latency: got %0t want 20", done_t - eof_cv); end
    n_cmp++; if (!act_seen || frame_active !== 1'b0) begin
      n_bad++; $display("FAIL a5_active: seen %b now %b want 1/0", act_seen, frame_active);
    end
  endtask

  task automatic test_bad_sof();
    for (int k = 0; k < 2; k++) begin
      clr_mon();
      reps(1'b1, (k == 0) ? 10 : 14); reps(1'b0, 4); reps(1'b1, 4); send_byte(8'h0F); idle_gap();
      n_cmp++; if (act_seen || done_cnt != 0 || rx_q.size() != 0) begin
        n_bad++; $display("FAIL bad_sof_%0d: active %b done %0d bytes %0d want 0/0/0", k, act_seen, done_cnt, rx_q.size());
      end
    end
  endtask

  task automatic test_hysteresis();
    clr_mon(); idle_gap();
    rep_amp(14'(THR_HI));
    for (int i = 0; i < 11; i++) rep_amp(14'((i % 2) ? THR_HI - 1 : THR_LO + 1));
    rep_amp(14'(THR_LO - 1));
    for (int i = 0; i < 3; i++) rep_amp(14'((i % 2) ? THR_HI - 1 : THR_LO + 1));
    rep_amp(14'(THR_HI));
    for (int i = 0; i < 3; i++) rep_amp(14'((i % 2) ? THR_LO + 1 : THR_HI - 1));
    prev_l = 1'b1;
    send_byte(8'h5A); send_eof(); idle_gap();
    n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== 8'h5A || done_cnt != 1 || last_err !== 1'b0) begin
      n_bad++; $display("FAIL hyst_frame: bytes %0d done %0d err %b want 1 byte 5a, 1, 0", rx_q.size(), done_cnt, last_err);
    end
  endtask

  task automatic test_all_off();
    clr_mon(); send_sof(); reps(1'b0, 8);
    n_cmp++; if (done_cnt != 1 || last_err !== 1'b1) begin
      n_bad++; $display("FAIL alloff_first_symbol: done %0d err %b want 1/1", done_cnt, last_err);
    end
    reps(1'b0, 8);
    n_cmp++; if (done_cnt != 1 || rx_q.size() != 0 || frame_active !== 1'b0) begin
      n_bad++; $display("FAIL alloff_after: done %0d bytes %0d active %b want 1/0/0", done_cnt, rx_q.size(), frame_active);
    end
  endtask

  task automatic test_partial();
    clr_mon(); idle_gap(); send_sof(); send_byte(8'h3C); send_bit(1'b0); send_eof(); idle_gap();
    n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      n_bad++; $display("FAIL partial_byte: count %0d want 1 byte 3c", rx_q.size());
    end
    n_cmp++; if (done_cnt != 1 || last_err !== 1'b1 || last_bc != 9) begin
      n_bad++; $display("FAIL partial_status: done %0d err %b bits %0d want 1/1/9", done_cnt, last_err, last_bc);
    end
    n_cmp++; if (frame_error !== 1'b1) begin n_bad++; $display("FAIL partial_err_held: got %b want 1", frame_error); end
  endtask

  task automatic test_enable();
    clr_mon(); send_sof(); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(posedge clk); enable = 1'b0;
    repeat (4) @(posedge clk);
    n_cmp++; if (done_cnt != 1 || last_err !== 1'b1 || frame_active !== 1'b0 || rx_q.size() != 0) begin
      n_bad++; $display("FAIL enable_abort: done %0d err %b active %b bytes %0d want 1/1/0/0", done_cnt, last_err, frame_active, rx_q.size());
    end
    enable = 1'b1;
    idle_gap();
  endtask

  task automatic test_reset_mid();
    clr_mon(); send_sof(); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    reset = 1'b1;
    @(posedge clk);
    n_cmp++; if ({byte_out, bit_cnt, byte_valid, frame_active, frame_done, frame_error} !== 22'd0 || done_cnt != 0) begin
      n_bad++; $display("FAIL reset_mid: outputs %h done %0d want 0/0", {byte_out, bit_cnt, byte_valid, frame_active, frame_done, frame_error}, done_cnt);
    end
    reset = 1'b0; prev_l = 1'b0;
    idle_gap(); send_sof(); send_byte(8'h01); send_eof(); idle_gap();
    n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== 8'h01 || done_cnt != 1 || last_err !== 1'b0 || last_bc != 8) begin
      n_bad++; $display("FAIL reset_mid_next: bytes %0d done %0d err %b bits %0d want 1x01/1/0/8", rx_q.size(), done_cnt, last_err, last_bc);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      logic [7:0] exp_q[$];
      int nb, extra, bad;
      nb = $urandom_range(1, 3);
      extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
      clr_mon(); send_sof();
      for (int b = 0; b < nb; b++) begin
        exp_q.push_back(8'($urandom_range(0, 255)));
        send_byte(exp_q[b]);
      end
      for (int e = 0; e < extra; e++) send_bit(1'($urandom_range(0, 1)));
      send_eof(); idle_gap();
      bad = (rx_q.size() != exp_q.size()) ? 1 : 0;
      for (int b = 0; b < exp_q.size() && b < rx_q.size(); b++) if (rx_q[b] !== exp_q[b]) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rand_bytes_%0d: %0d wrong of %0d, got %0d bytes", f, bad, nb, rx_q.size()); end
      n_cmp++; if (done_cnt != 1 || last_err !== (extra != 0) || last_bc != 8 * nb + extra) begin
        n_bad++; $display("FAIL rand_status_%0d: done %0d err %b bits %0d want 1/%b/%0d", f, done_cnt, last_err, last_bc, extra != 0, 8 * nb + extra);
      end
    end
  endtask

  task automatic test_max_bytes();
    logic [7:0] exp_q[$];
    int bad;
    gap = 4;
    clr_mon(); send_sof();
    for (int b = 0; b < 64; b++) begin
      exp_q.push_back(8'($urandom_range(0, 255)));
      send_byte(exp_q[b]);
    end
    send_bit(1'b0); idle_gap();
    bad = (rx_q.size() != 64) ? 1 : 0;
    for (int b = 0; b < 64 && b < rx_q.size(); b++) if (rx_q[b] !== exp_q[b]) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL max_bytes_data: %0d wrong, got %0d bytes want 64", bad, rx_q.size()); end
    n_cmp++; if (done_cnt != 1 || last_err !== 1'b1 || last_bc != 512) begin
      n_bad++; $display("FAIL max_bytes_status: done %0d err %b bits %0d want 1/1/512", done_cnt, last_err, last_bc);
    end
    gap = 16;
  endtask

  initial begin
    test_reset();
    test_a5_frame();
    test_bad_sof();
    test_hysteresis();
    test_all_off();
    test_partial();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    test_max_bytes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
